// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: FSM state encoding, word width
// and the HD44780-style command words used by the content generators.
package lcd_pkg;

    localparam int LCD_WORD_W = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_DELAY = 3'd3,
        S_INIT  = 3'd4
    } lcd_state_e;

    localparam logic [LCD_WORD_W-1:0] LCD_CMD_FUNC  = 9'h038;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_DISP  = 9'h00C;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_CLR   = 9'h001;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_ENTRY = 9'h006;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_LINE1 = 9'h080;
    localparam logic [LCD_WORD_W-1:0] LCD_CMD_LINE2 = 9'h0C0;

    // Power-up command issued at position idx of the init sequence.
    function automatic logic [LCD_WORD_W-1:0] lcd_init_word(input logic [1:0] idx);
        logic [LCD_WORD_W-1:0] word;
        case (idx)
            2'd0:    word = LCD_CMD_FUNC;
            2'd1:    word = LCD_CMD_DISP;
            2'd2:    word = LCD_CMD_CLR;
            2'd3:    word = LCD_CMD_ENTRY;
            default: word = LCD_CMD_FUNC;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Two-way round-robin selector: turns requester VALIDs and the fairness
// pointer (0 favours requester 0) into a one-hot grant.
module lcd_rr_pick
    import lcd_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot pick; the pointer only matters when both requesters are waiting.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Message-granular arbiter sharing one LCD_Controller write port between two
// requesters. Define LCD_INIT_SEQ_EN to issue the power-up commands after reset.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int               DLY_W      = 18,
    parameter logic [DLY_W-1:0] DLY_CYCLES = 18'h3FFFE
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iREQ0_VALID,
    input  logic [8:0] iREQ0_DATA,
    input  logic       iREQ0_LAST,
    output logic       oREQ0_READY,
    input  logic       iREQ1_VALID,
    input  logic [8:0] iREQ1_DATA,
    input  logic       iREQ1_LAST,
    output logic       oREQ1_READY,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_START,
    input  logic       iLCD_DONE,
    output logic [1:0] oGRANT,
    output logic       oBUSY
);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_CYCLES - DLY_W'(1);

    lcd_state_e                state_q, state_d;
    logic [1:0]                grant_q, grant_d;
    logic                      ptr_q, ptr_d;
    logic [DLY_W-1:0]          cnt_q, cnt_d;
    logic [LCD_WORD_W-1:0]     data_q, data_d;
    logic                      last_q, last_d;
    logic                      start_q, start_d;
    logic                      busy_q, busy_d;
`ifdef LCD_INIT_SEQ_EN
    logic [1:0]                init_idx_q, init_idx_d;
    logic                      init_q, init_d;
`endif

    logic [1:0] pick_s;
    logic       rdy0_s;
    logic       rdy1_s;
    logic       acc_s;
    logic       word_done_s;

    lcd_rr_pick u_pick (
        .valid ({iREQ1_VALID, iREQ0_VALID}),
        .ptr   (ptr_q),
        .grant (pick_s)
    );

    assign rdy0_s = (state_q == S_LOAD) && grant_q[0];
    assign rdy1_s = (state_q == S_LOAD) && grant_q[1];
    assign acc_s  = (rdy0_s && iREQ0_VALID) || (rdy1_s && iREQ1_VALID);

    // Next-state, grant, holding-register and settle-counter logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        last_d      = last_q;
        word_done_s = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_idx_d  = init_idx_q;
        init_d      = init_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_s != 2'b00) begin
                    grant_d = pick_s;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (acc_s) begin
                    if (grant_q[1]) begin
                        data_d = iREQ1_DATA;
                        last_d = iREQ1_LAST;
                    end else begin
                        data_d = iREQ0_DATA;
                        last_d = iREQ0_LAST;
                    end
                    state_d = S_EXEC;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_EXEC: begin
                if (iLCD_DONE) begin
                    if (DLY_CYCLES != '0) begin
                        state_d = S_DELAY;
                    end else begin
                        word_done_s = 1'b1;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DELAY: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d       = '0;
                    word_done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + DLY_W'(1);
                end
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT: begin
                // The last init word reuses the LAST path to leave the sequence.
                data_d  = lcd_init_word(init_idx_q);
                last_d  = (init_idx_q == 2'd3);
                state_d = S_EXEC;
            end
`endif
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (word_done_s) begin
`ifdef LCD_INIT_SEQ_EN
            if (init_q) begin
                if (last_q) begin
                    init_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = S_INIT;
                end
            end else begin
`endif
                if (last_q) begin
                    // Message finished: hand priority to the other requester.
                    grant_d = 2'b00;
                    ptr_d   = grant_q[0];
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
`ifdef LCD_INIT_SEQ_EN
            end
`endif
        end else begin
            ptr_d = ptr_q;
        end

        start_d = (state_d == S_EXEC);
        busy_d  = (state_d != S_IDLE);
    end

    // State and datapath registers; reset abandons any message in flight.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
`ifdef LCD_INIT_SEQ_EN
            state_q    <= S_INIT;
            init_idx_q <= 2'd0;
            init_q     <= 1'b1;
`else
            state_q    <= S_IDLE;
`endif
            grant_q    <= 2'b00;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            data_q     <= 9'h000;
            last_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q <= init_idx_d;
            init_q     <= init_d;
`endif
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign oREQ0_READY = rdy0_s;
    assign oREQ1_READY = rdy1_s;
    assign oLCD_DATA   = data_q[7:0];
    assign oLCD_RS     = data_q[8];
    assign oLCD_START  = start_q;
    assign oGRANT      = grant_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter against a message-level round-robin
// model; an LCD_Controller stand-in returns DONE two cycles after each START.
module tb_lcd_write_arbiter;
    import lcd_pkg::*;

    localparam logic [17:0] DLY = 18'd4;
    localparam int          LAT = 5;

    logic       clk, rst_n;
    logic       vld0, vld1, lst0, lst1, rdy0, rdy1;
    logic [8:0] dat0, dat1;
    logic [7:0] lcd_data;
    logic       lcd_rs, start, busy;
    logic       resp_done, poke_done, extra_done;
    logic [1:0] grant;
    wire        done_s = resp_done | poke_done;

    typedef struct { logic [8:0] word; logic last; int req; } exp_t;
    exp_t       exp_q[$];
    logic [9:0] q0[$], q1[$], m0[$], m1[$];
    logic       mp;
    int         vectors, errors;

    lcd_write_arbiter #(.DLY_W(18), .DLY_CYCLES(DLY)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iREQ0_VALID(vld0), .iREQ0_DATA(dat0), .iREQ0_LAST(lst0), .oREQ0_READY(rdy0),
        .iREQ1_VALID(vld1), .iREQ1_DATA(dat1), .iREQ1_LAST(lst1), .oREQ1_READY(rdy1),
        .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs), .oLCD_START(start), .iLCD_DONE(done_s),
        .oGRANT(grant), .oBUSY(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester 0 driver: presents queued words, pops on acceptance.
    initial begin
        vld0 = 1'b0; dat0 = 9'h000; lst0 = 1'b0;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                vld0 = 1'b1;
                {lst0, dat0} = q0[0];
                if (rdy0) begin
                    @(posedge clk); #1;
                    if (q0.size() > 0) void'(q0.pop_front());
                    if (q0.size() > 0) {lst0, dat0} = q0[0];
                    else begin vld0 = 1'b0; dat0 = 9'($urandom); end
                end
            end else vld0 = 1'b0;
        end
    end

    // Requester 1 driver.
    initial begin
        vld1 = 1'b0; dat1 = 9'h000; lst1 = 1'b0;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                vld1 = 1'b1;
                {lst1, dat1} = q1[0];
                if (rdy1) begin
                    @(posedge clk); #1;
                    if (q1.size() > 0) void'(q1.pop_front());
                    if (q1.size() > 0) {lst1, dat1} = q1[0];
                    else begin vld1 = 1'b0; dat1 = 9'($urandom); end
                end
            end else vld1 = 1'b0;
        end
    end

    // LCD_Controller stand-in.
    initial begin
        logic rs_prev;
        resp_done = 1'b0; rs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (start && !rs_prev) begin
                repeat (2) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                if (extra_done) begin
                    @(negedge clk); resp_done = 1'b1;
                    @(negedge clk); resp_done = 1'b0;
                end
            end
            rs_prev = start;
        end
    end

    // Output monitor: word order, grant, latencies, READY exclusivity.
    initial begin
        logic mon_prev, arm, acc_prev, cur_last;
        int   cyc, cur_req;
        exp_t e;
        logic [1:0] expg;
        mon_prev = 1'b0; arm = 1'b0; acc_prev = 1'b0; cyc = 0; cur_req = -1; cur_last = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arm = 1'b0; acc_prev = 1'b0; mon_prev = 1'b0;
            end else begin
                if (acc_prev) begin
                    vectors++;
                    if (start !== 1'b1) begin
                        errors++; $display("FAIL accept_to_start start=%b required=1", start);
                    end
                end
                acc_prev = (vld0 && rdy0) || (vld1 && rdy1);
                if (start && !mon_prev) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL unexpected_start word=%h required none", {lcd_rs, lcd_data});
                    end else begin
                        e = exp_q.pop_front();
                        expg = (e.req < 0) ? 2'b00 : ((e.req == 0) ? 2'b01 : 2'b10);
                        if ({lcd_rs, lcd_data} !== e.word || grant !== expg || busy !== 1'b1) begin
                            errors++;
                            $display("FAIL lcd_word got word=%h grant=%b busy=%b required word=%h grant=%b busy=1",
                                     {lcd_rs, lcd_data}, grant, busy, e.word, expg);
                        end
                        cur_last = e.last; cur_req = e.req;
                    end
                end
                if (start && done_s && cur_req >= 0 && !cur_last) begin
                    arm = 1'b1; cyc = 0;
                end else if (arm) begin
                    cyc++;
                    if (rdy0 || rdy1) begin
                        vectors++; arm = 1'b0;
                        if (cyc != LAT) begin
                            errors++; $display("FAIL done_to_ready cycles=%0d required=%0d", cyc, LAT);
                        end
                    end else if (cyc > 3 * LAT) begin
                        vectors++; errors++; arm = 1'b0;
                        $display("FAIL done_to_ready cycles>%0d required=%0d", 3 * LAT, LAT);
                    end
                end
                if (rdy0 || rdy1) begin
                    vectors++;
                    if ((rdy0 && grant !== 2'b01) || (rdy1 && grant !== 2'b10)) begin
                        errors++; $display("FAIL ready_owner rdy=%b%b grant=%b required ready only for owner", rdy1, rdy0, grant);
                    end
                end
                mon_prev = start;
            end
        end
    end

    task automatic enqueue_word(input int r, input logic [8:0] w, input logic l);
        if (r == 0) begin q0.push_back({l, w}); m0.push_back({l, w}); end
        else        begin q1.push_back({l, w}); m1.push_back({l, w}); end
    endtask

    task automatic enqueue_rand(input int r, input int len);
        for (int i = 0; i < len; i++) enqueue_word(r, 9'($urandom), (i == len - 1));
    endtask

    // Message-level reference: whole messages, alternating when both wait.
    task automatic model_resolve();
        int         pick;
        logic [9:0] w;
        exp_t       e;
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) pick = mp ? 1 : 0;
            else pick = (m0.size() > 0) ? 0 : 1;
            do begin
                w = (pick == 1) ? m1.pop_front() : m0.pop_front();
                e.word = w[8:0]; e.last = w[9]; e.req = pick;
                exp_q.push_back(e);
            end while (!w[9]);
            mp = (pick == 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 3000 && !(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                             !busy && !vld0 && !vld1)) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n >= 3000) begin
            errors++; $display("FAIL idle_timeout pending=%0d busy=%b required pending=0 busy=0", exp_q.size(), busy);
        end
        vectors++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL idle_grant grant=%b required=00", grant);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0;
        q0.delete(); q1.delete(); m0.delete(); m1.delete(); exp_q.delete();
        repeat (5) @(negedge clk);
        vectors++;
        if ({start, grant, busy, rdy0, rdy1, lcd_rs, lcd_data} !== 15'h0000) begin
            errors++;
            $display("FAIL reset_outputs start=%b grant=%b busy=%b rdy=%b%b word=%h required all 0",
                     start, grant, busy, rdy1, rdy0, {lcd_rs, lcd_data});
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        mp = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        e.req = -1; e.last = 1'b0;
        e.word = LCD_CMD_FUNC;  exp_q.push_back(e);
        e.word = LCD_CMD_DISP;  exp_q.push_back(e);
        e.word = LCD_CMD_CLR;   exp_q.push_back(e);
        e.word = LCD_CMD_ENTRY; e.last = 1'b1; exp_q.push_back(e);
`endif
    endtask

    task automatic test_reset();
        do_reset();
`ifdef LCD_INIT_SEQ_EN
        enqueue_rand(0, 2);
        model_resolve();
`endif
        wait_idle();
    endtask

    task automatic test_single_req();
        @(posedge clk); #2;
        enqueue_word(0, 9'h144, 1'b0);
        enqueue_word(0, 9'h16F, 1'b0);
        enqueue_word(0, 9'h120, 1'b1);
        model_resolve();
        wait_idle();
    endtask

    task automatic test_alternation();
        do_reset();
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            enqueue_rand(0, 2);
            enqueue_rand(1, 2);
            model_resolve();
            wait_idle();
        end
    endtask

    task automatic test_hold_off();
        @(posedge clk); #2;
        enqueue_rand(0, 2);
        model_resolve();
        repeat (2) @(posedge clk); #2;
        enqueue_rand(1, 3);
        model_resolve();
        wait_idle();
    endtask

    task automatic test_done_ignored();
        @(negedge clk); poke_done = 1'b1;
        @(negedge clk); poke_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (start !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_done start=%b busy=%b required 0 0", start, busy);
            end
        end
        extra_done = 1'b1;
        @(posedge clk); #2;
        enqueue_rand(1, 3);
        model_resolve();
        wait_idle();
        extra_done = 1'b0;
    endtask

    task automatic test_random();
        int n0, n1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 2);
            for (int j = 0; j < n0; j++) enqueue_rand(0, $urandom_range(1, 4));
            for (int j = 0; j < n1; j++) enqueue_rand(1, $urandom_range(1, 4));
            model_resolve();
            wait_idle();
        end
    endtask

    task automatic test_reset_mid_exec();
        int n = 0;
        @(posedge clk); #2;
        enqueue_rand(1, 3);
        model_resolve();
        while (n < 200 && start !== 1'b1) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 200) begin
            errors++; $display("FAIL start_timeout start=%b required=1", start);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({start, grant, busy, rdy0, rdy1} !== 6'b000000) begin
            errors++;
            $display("FAIL async_reset start=%b grant=%b busy=%b rdy=%b%b required all 0", start, grant, busy, rdy1, rdy0);
        end
        do_reset();
        @(posedge clk); #2;
        enqueue_rand(1, 2);
        enqueue_rand(0, 1);
        model_resolve();
        wait_idle();
    endtask

    initial begin
        vectors = 0; errors = 0; mp = 1'b0;
        rst_n = 1'b0; poke_done = 1'b0; extra_done = 1'b0;
        test_reset();
        test_single_req();
        test_alternation();
        test_hold_off();
        test_done_ignored();
        test_random();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
